cmos_cfg_sequencer: RTL

Sequences OV5640 register configuration for both cameras through one shared SCCB write engine. Walks the register table once per camera (CMOS1 first, then CMOS2), retries NACKed writes, handles table-embedded delays, and raises per-camera done flags. Sits between `power_on_delay` and the two camera SCCB buses. Replaces the duplicated per-camera configuration engines with a single scheduled resource.

---
 rtl/cmos_cfg_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cmos_cfg_sequencer.sv
// Shared OV5640 configuration sequencer: walks the register table for cmos1, then cmos2, through one SCCB write engine.
// Optional build macro CMOS_CFG_DELAY_EN: entries with reg_addr 16'hFFFF become reg_data-millisecond delays.
module cmos_cfg_sequencer #(
  parameter int         REG_NUM    = 252,
  parameter int         IDX_W      = 9,
  parameter logic [7:0] DEV_ADDR   = 8'h78,
  parameter int         RETRY_MAX  = 3,
  parameter int         DELAY_UNIT = 25000
) (
  input  logic             clk_25M,
  input  logic             reset_n,
  input  logic             initial_en,
  input  logic [1:0]       cam_rstn,
  output logic [IDX_W-1:0] tbl_index,
  input  logic [23:0]      tbl_data,
  output logic             sccb_start,
  output logic             sccb_sel,
  output logic [7:0]       sccb_dev,
  output logic [15:0]      sccb_addr,
  output logic [7:0]       sccb_wdata,
  input  logic             sccb_done,
  input  logic             sccb_nack,
  output logic [1:0]       cfg_done,
  output logic [1:0]       cfg_err,
  output logic             busy
);
  localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_CAM, S_FETCH, S_LATCH, S_ISSUE, S_WAIT, S_RETRY, S_NEXT,
`ifdef CMOS_CFG_DELAY_EN
    S_DELAY,
`endif
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               cam_q, cam_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic               abort_q, abort_d;
  logic               start_q, sel_q, busy_q;
  logic               cam_lost_s, abort_s;

`ifdef CMOS_CFG_DELAY_EN
  localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
  logic [CNT_W-1:0]   dly_q, dly_d;
`endif

  assign cam_lost_s = ~cam_rstn[cam_q];

  // Next-state and datapath decisions; a camera dropping into reset is folded in after the case.
  always_comb begin
    state_d = state_q;
    cam_d   = cam_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    retry_d = retry_q;
    done_d  = done_q;
    err_d   = err_q;
    abort_d = abort_q;
    abort_s = 1'b0;
`ifdef CMOS_CFG_DELAY_EN
    dly_d   = dly_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (initial_en) begin
          cam_d   = 1'b0;
          state_d = S_WAIT_CAM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_CAM: begin
        if (cam_rstn[cam_q]) begin
          idx_d   = {IDX_W{1'b0}};
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT_CAM;
        end
      end
      S_FETCH: begin
        if (cam_lost_s) abort_s = 1'b1;
        else            state_d = S_LATCH;
      end
      S_LATCH: begin
        if (cam_lost_s) begin
          abort_s = 1'b1;
        end else begin
          addr_d  = tbl_data[23:8];
          wdata_d = tbl_data[7:0];
          retry_d = {RTY_W{1'b0}};
`ifdef CMOS_CFG_DELAY_EN
          if (tbl_data[23:8] == 16'hFFFF) begin
            if (tbl_data[7:0] == 8'd0) begin
              state_d = S_NEXT;
            end else begin
              dly_d   = CNT_W'(tbl_data[7:0]) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
              state_d = S_DELAY;
            end
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (cam_lost_s) abort_s = 1'b1;
        else            state_d = S_WAIT;
      end
      // A reset seen while a write is outstanding is remembered until that write's done arrives.
      S_WAIT: begin
        if (sccb_done) begin
          if (abort_q || cam_lost_s) begin
            abort_s = 1'b1;
          end else if (!sccb_nack) begin
            state_d = S_NEXT;
          end else if (retry_q < RTY_W'(RETRY_MAX)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = S_RETRY;
          end else begin
            err_d[cam_q] = 1'b1;
            state_d      = S_NEXT;
          end
        end else begin
          abort_d = abort_q | cam_lost_s;
        end
      end
      S_RETRY: begin
        if (cam_lost_s) abort_s = 1'b1;
        else            state_d = S_ISSUE;
      end
`ifdef CMOS_CFG_DELAY_EN
      S_DELAY: begin
        if (cam_lost_s) begin
          abort_s = 1'b1;
        end else if (dly_q == {CNT_W{1'b0}}) begin
          state_d = S_NEXT;
        end else begin
          dly_d = dly_q - CNT_W'(1);
        end
      end
`endif
      S_NEXT: begin
        if (cam_lost_s) begin
          abort_s = 1'b1;
        end else if (idx_q == IDX_W'(REG_NUM - 1)) begin
          done_d[cam_q] = 1'b1;
          if (cam_q == 1'b0) begin
            cam_d   = 1'b1;
            state_d = S_WAIT_CAM;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (abort_s) begin
      state_d      = S_WAIT_CAM;
      idx_d        = {IDX_W{1'b0}};
      err_d[cam_q] = 1'b0;
      abort_d      = 1'b0;
    end else begin
      abort_d = abort_d & (state_d == S_WAIT);
    end
  end

  // State, datapath and registered bus outputs.
  always_ff @(posedge clk_25M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cam_q   <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      retry_q <= {RTY_W{1'b0}};
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      abort_q <= 1'b0;
      start_q <= 1'b0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cam_q   <= cam_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      start_q <= (state_d == S_ISSUE);
      sel_q   <= cam_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

`ifdef CMOS_CFG_DELAY_EN
  // Millisecond delay down-counter, loaded on a delay entry.
  always_ff @(posedge clk_25M or negedge reset_n) begin
    if (!reset_n) dly_q <= {CNT_W{1'b0}};
    else          dly_q <= dly_d;
  end
`endif

  assign tbl_index  = idx_q;
  assign sccb_start = start_q;
  assign sccb_sel   = sel_q;
  assign sccb_dev   = DEV_ADDR;
  assign sccb_addr  = addr_q;
  assign sccb_wdata = wdata_q;
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign busy       = busy_q;
endmodule
